// File: rtl/adrv9001_spi_master_if.sv
// Command/response bundle between the control-plane register bank and the
// ADRV9001 SPI master.
interface adrv9001_spi_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/adrv9001_spi_master.sv
// SPI mode-0 master for the ADRV9001 control port: one 24-bit frame
// {rw, addr, data} per accepted command, returning the last MISO byte.
module adrv9001_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  adrv9001_spi_master_if.slave cmd,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  output logic                 spi_csn,
  input  logic                 spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] tx;
  logic [7:0]  rx;

  // tx holds the frame bits still to be driven, already advanced past the
  // bit currently on mosi, so each falling edge just takes tx[23].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      tx            <= '0;
      rx            <= '0;
      spi_sclk      <= 1'b0;
      spi_mosi      <= 1'b0;
      spi_csn       <= 1'b1;
      cmd.cmd_ready <= 1'b1;
      cmd.busy      <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= '0;
    end else begin
      cmd.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            tx            <= {cmd.cmd_addr, cmd.cmd_wdata, 1'b0};
            spi_mosi      <= cmd.cmd_rw;
            spi_csn       <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            cmd.busy      <= 1'b1;
            cnt           <= '0;
            bit_cnt       <= '0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              rx       <= {rx[6:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 5'd23) begin
                spi_mosi <= 1'b0;
                state    <= HOLD;
              end else begin
                spi_mosi <= tx[23];
                tx       <= {tx[22:0], 1'b0};
                bit_cnt  <= bit_cnt + 5'd1;
              end
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt           <= '0;
            spi_csn       <= 1'b1;
            cmd.rsp_valid <= 1'b1;
            cmd.rsp_rdata <= rx;
            state         <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt           <= '0;
            cmd.cmd_ready <= 1'b1;
            cmd.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adrv9001_spi_master.sv
// Directed bench for adrv9001_spi_master: a default-parameter instance and a
// minimum-timing instance, with a MISO slave model and an SPI pin monitor.
module tb_adrv9001_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel       = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw    = 1'b0;
  logic [14:0] cmd_addr  = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [23:0] miso_word = '0;
  logic        spi_miso;

  logic sclk_a, mosi_a, csn_a;
  logic sclk_b, mosi_b, csn_b;

  adrv9001_spi_master_if bus_a ();
  adrv9001_spi_master_if bus_b ();

  assign bus_a.cmd_valid = cmd_valid & ~sel;
  assign bus_a.cmd_rw    = cmd_rw;
  assign bus_a.cmd_addr  = cmd_addr;
  assign bus_a.cmd_wdata = cmd_wdata;
  assign bus_b.cmd_valid = cmd_valid & sel;
  assign bus_b.cmd_rw    = cmd_rw;
  assign bus_b.cmd_addr  = cmd_addr;
  assign bus_b.cmd_wdata = cmd_wdata;

  adrv9001_spi_master dut_a (
    .clk      (clk),
    .rst      (rst),
    .cmd      (bus_a),
    .spi_sclk (sclk_a),
    .spi_mosi (mosi_a),
    .spi_csn  (csn_a),
    .spi_miso (spi_miso)
  );

  adrv9001_spi_master #(
    .CLK_DIV  (1),
    .CS_SETUP (1),
    .CS_HOLD  (1),
    .CS_GAP   (1)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .cmd      (bus_b),
    .spi_sclk (sclk_b),
    .spi_mosi (mosi_b),
    .spi_csn  (csn_b),
    .spi_miso (spi_miso)
  );

  logic       m_sclk, m_mosi, m_csn, m_ready, m_busy, m_rsp_valid;
  logic [7:0] m_rdata;
  assign m_sclk      = sel ? sclk_b : sclk_a;
  assign m_mosi      = sel ? mosi_b : mosi_a;
  assign m_csn       = sel ? csn_b  : csn_a;
  assign m_ready     = sel ? bus_b.cmd_ready : bus_a.cmd_ready;
  assign m_busy      = sel ? bus_b.busy      : bus_a.busy;
  assign m_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign m_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;

  int checks = 0;
  int errors = 0;

  int cyc = 0, rise_cnt = 0, low_len = 0, toggles = 0, rsp_cnt = 0;
  int proto_err = 0, ready_busy = 0;
  int fall_cyc = 0, rise_cyc = 0, rsp_cyc = 0, gap_len = 0;
  int frame_rises = 0, frame_len = 0, frame_toggles = 0;
  logic [23:0] mosi_cap = '0, frame_mosi = '0;
  logic p_sclk = 1'b0, p_csn = 1'b1, p_mosi = 1'b0;

  // Slave model: presents the next miso_word bit ahead of each SCLK rise.
  always_comb begin
    spi_miso = 1'b0;
    if (rise_cnt < 24) spi_miso = miso_word[5'(23 - rise_cnt)];
  end

  // Pin monitor sampled on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    cyc    <= cyc + 1;
    p_sclk <= m_sclk;
    p_csn  <= m_csn;
    p_mosi <= m_mosi;
    if (!rst) begin
      if (p_sclk && m_sclk && (m_mosi !== p_mosi)) proto_err <= proto_err + 1;
      if (p_csn && m_csn && (m_sclk !== p_sclk))   proto_err <= proto_err + 1;
      if ((m_csn !== p_csn) && m_sclk)             proto_err <= proto_err + 1;
      if (m_ready && (m_busy || !m_csn))           ready_busy <= ready_busy + 1;
      if (m_rsp_valid) begin
        rsp_cnt <= rsp_cnt + 1;
        rsp_cyc <= cyc;
      end
    end
    if (!m_csn && p_csn) begin
      low_len  <= 1;
      toggles  <= 0;
      fall_cyc <= cyc;
      gap_len  <= cyc - rise_cyc;
    end else if (!m_csn) begin
      low_len <= low_len + 1;
      if (m_sclk !== p_sclk) toggles <= toggles + 1;
    end
    if (m_csn && !p_csn) begin
      rise_cyc      <= cyc;
      frame_rises   <= rise_cnt;
      frame_len     <= low_len;
      frame_toggles <= toggles;
      frame_mosi    <= mosi_cap;
    end
    if (m_csn) begin
      rise_cnt <= 0;
    end else if (m_sclk && !p_sclk) begin
      rise_cnt <= rise_cnt + 1;
      mosi_cap <= {mosi_cap[22:0], m_mosi};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command and returns just after the edge that accepts it;
  // hold leaves cmd_valid asserted for a back-to-back follow-up.
  task automatic applyStimulus(input logic rw, input logic [14:0] addr,
                               input logic [7:0] wdata, input logic hold);
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (m_ready) break;
      @(negedge clk); #1;
    end
    checkOutput("accept_wait", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = hold;
  endtask

  task automatic waitRsp(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (rsp_cnt >= target) break;
      @(negedge clk); #1;
    end
    checkOutput("rsp_wait", 32'(rsp_cnt >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_csn",     32'(csn_a),           32'd1);
    checkOutput("rst_sclk",    32'(sclk_a),          32'd0);
    checkOutput("rst_mosi",    32'(mosi_a),          32'd0);
    checkOutput("rst_ready",   32'(bus_a.cmd_ready), 32'd1);
    checkOutput("rst_busy",    32'(bus_a.busy),      32'd0);
    checkOutput("rst_rvalid",  32'(bus_a.rsp_valid), 32'd0);
    checkOutput("rst_rdata",   32'(bus_a.rsp_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    $display("[TB] write 0x0123 <- 0xA5");
    miso_word = 24'h00005A;
    base = rsp_cnt;
    applyStimulus(1'b0, 15'h0123, 8'hA5, 1'b0);
    checkOutput("wr_busy", 32'(bus_a.busy), 32'd1);
    waitRsp(base + 1);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("wr_mosi",    32'(frame_mosi),       32'h0123A5);
    checkOutput("wr_rises",   32'(frame_rises),      32'd24);
    checkOutput("wr_toggles", 32'(frame_toggles),    32'd48);
    checkOutput("wr_csn_low", 32'(frame_len),        32'd196);
    checkOutput("wr_rsp_lat", 32'(rsp_cyc - fall_cyc), 32'd196);
    checkOutput("wr_rsp_csn", 32'(rsp_cyc - rise_cyc), 32'd0);
    checkOutput("wr_pulse",   32'(rsp_cnt - base),   32'd1);
    checkOutput("wr_rdata",   32'(bus_a.rsp_rdata),  32'h5A);

    $display("[TB] reset during shift");
    base = rsp_cnt;
    applyStimulus(1'b0, 15'h0123, 8'hA5, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (rise_cnt >= 8 && m_sclk) break;
      @(negedge clk); #1;
    end
    checkOutput("mid_sclk_hi", 32'(sclk_a), 32'd1);
    checkOutput("mid_mosi_hi", 32'(mosi_a), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_csn",   32'(csn_a),           32'd1);
    checkOutput("abort_sclk",  32'(sclk_a),          32'd0);
    checkOutput("abort_mosi",  32'(mosi_a),          32'd0);
    checkOutput("abort_ready", 32'(bus_a.cmd_ready), 32'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    checkOutput("abort_norsp", 32'(rsp_cnt - base),  32'd0);
    checkOutput("abort_idle",  32'(bus_a.cmd_ready), 32'd1);
    checkOutput("abort_csn2",  32'(csn_a),           32'd1);

    $display("[TB] read 0x7FFF");
    miso_word = 24'h00003C;
    base = rsp_cnt;
    applyStimulus(1'b1, 15'h7FFF, 8'h00, 1'b0);
    waitRsp(base + 1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rd_mosi",  32'(frame_mosi),      32'hFFFF00);
    checkOutput("rd_rises", 32'(frame_rises),     32'd24);
    checkOutput("rd_rdata", 32'(bus_a.rsp_rdata), 32'h3C);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("rd_hold",  32'(bus_a.rsp_rdata), 32'h3C);

    $display("[TB] back-to-back commands");
    miso_word = 24'h000096;
    base = rsp_cnt;
    applyStimulus(1'b0, 15'h5555, 8'h0F, 1'b1);
    applyStimulus(1'b1, 15'h2AAA, 8'hC3, 1'b0);
    checkOutput("b2b_mosi1",  32'(frame_mosi),      32'h55550F);
    checkOutput("b2b_rdata1", 32'(bus_a.rsp_rdata), 32'h96);
    waitRsp(base + 2);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("b2b_gap",    32'(gap_len),         32'd5);
    checkOutput("b2b_mosi2",  32'(frame_mosi),      32'hAAAAC3);
    checkOutput("b2b_len2",   32'(frame_len),       32'd196);
    checkOutput("b2b_rsps",   32'(rsp_cnt - base),  32'd2);
    repeat (10) @(negedge clk);

    $display("[TB] minimum timing instance");
    sel = 1'b1;
    miso_word = 24'h0000C7;
    @(negedge clk); #1;
    base = rsp_cnt;
    applyStimulus(1'b0, 15'h1234, 8'h5A, 1'b0);
    waitRsp(base + 1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("fast_mosi",    32'(frame_mosi),       32'h12345A);
    checkOutput("fast_rises",   32'(frame_rises),      32'd24);
    checkOutput("fast_toggles", 32'(frame_toggles),    32'd48);
    checkOutput("fast_csn_low", 32'(frame_len),        32'd50);
    checkOutput("fast_rsp_lat", 32'(rsp_cyc - fall_cyc), 32'd50);
    checkOutput("fast_rdata",   32'(m_rdata),          32'hC7);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("fast_idle",    32'(m_ready),          32'd1);

    checkOutput("protocol",    32'(proto_err),  32'd0);
    checkOutput("ready_busy",  32'(ready_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
